div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Iterative radix-2 restoring divider with its sequencing FSM for the M-extension DIV/DIVU/REM/REMU instructions.
- Sits beside the EXE stage. It receives the divide request from EXE and returns the one-cycle div_ack consumed by the pipeline stall/forward controller.
- Handles RISC-V special cases and aborts on pipeline flush.

Parameters:
- XLEN, 32, operand/result width. Iteration count equals XLEN.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- div_req_i  input  1  level request from EXE; stays high while the pipeline is stalled on this instruction
- div_op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  input  XLEN  rs1 operand, sampled at start
- divisor_i  input  XLEN  rs2 operand, sampled at start
- flush_i  input  1  pipeline flush (CSR new PC / WFI); aborts the operation
- div_ack_o  output  1  one-cycle pulse; div_result_o is valid in the same cycle
- div_result_o  output  XLEN  quotient or remainder
- div_busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset:
  - state is IDLE.
  - div_ack_o, div_busy_o and div_result_o are 0.
  - All internal registers (remainder, quotient, divisor, counter, sign flags, op) are 0.
- States and transitions:
  - IDLE: if div_req_i and not flush_i, capture the operands and op.
    - Special case (divisor 0, or signed overflow) goes to DONE.
    - Otherwise go to PREP.
  - PREP: for signed ops, take absolute values and record the quotient sign (sign(a) xor sign(b)) and the remainder sign (sign(a)). Counter is set to XLEN-1. Go to CALC.
  - CALC, one iteration per cycle:
    - Shift {rem, quo} left by 1.
    - Compute trial = rem - divisor, using XLEN+1-bit subtraction.
    - If trial is non-negative, rem becomes trial and the quotient LSB is 1.
    - When the counter reaches 0, go to FIX; otherwise decrement the counter.
  - FIX: negate the quotient or remainder according to the recorded signs. Select quotient for DIV/DIVU, remainder for REM/REMU. Register the result. Go to DONE.
  - DONE: div_ack_o = 1 gated with ~flush_i. Go to IDLE unconditionally.
    - div_req_i still being high in DONE does not restart the divider.
- Latency, with the req-accept cycle as cycle 0:
  - Normal case: PREP in cycle 1, CALC in cycles 2..XLEN+1, FIX in XLEN+2, ack in XLEN+3 (cycle 35 for XLEN=32).
  - Special case: ack in cycle 1.
- Special-case results:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (dividend = 0x80000000, divisor = 0xFFFFFFFF, DIV/REM only):
    - DIV returns 0x80000000.
    - REM returns 0.
  - The unsigned ops never take the overflow path.
- Back-to-back operation:
  - The earliest possible re-accept is the cycle after DONE, i.e. IDLE, when div_req_i is high for the next instruction.
  - Ops are not overlapped.
- Flush:
  - In any state, flush_i forces the next state to IDLE and suppresses div_ack_o in the current cycle.
  - div_result_o holds its last value.
  - A flush in IDLE coincident with div_req_i blocks the accept.
- div_result_o holds its value until the next FIX or special-case capture.
- Asynchronous reset mid-operation returns the block to IDLE immediately; no ack is produced.
- Width rules:
  - The remainder register is XLEN+1 bits internally.
  - Negation is two's complement modulo 2^XLEN.
  - abs(0x80000000) is 0x80000000 treated as unsigned. This is correct for all non-overflow cases.

Decomposition:
- Shared package m_ext_pkg holds:
  - type_div_op_e (DIV/DIVU/REM/REMU, 2 bits)
  - type_div_state_e (IDLE, PREP, CALC, FIX, DONE)
  - the constant DIV_ITER = XLEN
- Sub-module div_step: purely combinational single iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: rem_next, quo_next.
  - Instantiated once inside div_seq.
- The FSM, counter and sign fix-up stay in div_seq.

Test Plan:
- DIVU: dividend 100, divisor 7, req held high -> ack exactly in cycle 35, result 14. busy high in cycles 1..35.
- REM: dividend 0xFFFFFFF9 (-7), divisor 2 -> result 0xFFFFFFFF (-1). Same operands with DIV -> 0xFFFFFFFD (-3).
- Divide by zero:
  - DIVU with any dividend and divisor 0 -> ack in cycle 1, result 0xFFFFFFFF.
  - REMU with dividend 0x1234 and divisor 0 -> ack in cycle 1, result 0x1234.
- Overflow: dividend 0x80000000, divisor 0xFFFFFFFF.
  - DIV -> 0x80000000 at cycle 1.
  - REM -> 0 at cycle 1.
  - DIVU -> 0 after the full latency.
- Flush: pulse flush_i in cycle 10 of a DIV -> no ack ever, busy low from cycle 11. A new req in cycle 11 (DIVU 9/3) -> ack at cycle 46, result 3.
- Reset and continuous req: rst_n asserted in cycle 20 -> outputs 0 asynchronously. After release, a held req (DIVU 0xFFFFFFFF/1) -> one ack, result 0xFFFFFFFF, no second ack in the DONE cycle.

Source files
------------

// File: rtl/m_ext_pkg.sv
// Shared M-extension types and constants for the iterative divider.
package m_ext_pkg;

  localparam int M_XLEN   = 32;
  localparam int DIV_ITER = M_XLEN;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } type_div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } type_div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step
  import m_ext_pkg::*;
#(
  parameter int XLEN = DIV_ITER
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_sh_s;
  logic [XLEN:0] trial_s;

  // Trial subtraction; the MSB of the XLEN+1-bit result is the borrow.
  always_comb begin
    rem_sh_s = {rem[XLEN-1:0], quo[XLEN-1]};
    trial_s  = rem_sh_s - {1'b0, divisor};
    if (!trial_s[XLEN]) begin
      rem_next = trial_s;
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = rem_sh_s;
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU with RISC-V
// divide-by-zero / overflow handling and flush abort.
module div_seq
  import m_ext_pkg::*;
#(
  parameter int XLEN = DIV_ITER
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_req_i,
  input  logic [1:0]      div_op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            div_ack_o,
  output logic [XLEN-1:0] div_result_o,
  output logic            div_busy_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE_C = {{(XLEN-1){1'b0}}, 1'b1};

  type_div_state_e state_r;
  type_div_op_e    op_r;
  logic [XLEN:0]   rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvs_r;
  logic [XLEN-1:0] result_r;
  logic [CNT_W-1:0] cnt_r;
  logic            quo_neg_r;
  logic            rem_neg_r;
  logic            ack_r;
  logic            busy_r;

  logic [XLEN:0]   rem_next_s;
  logic [XLEN-1:0] quo_next_s;
  logic            op_signed_s;
  logic            req_zero_s;
  logic            req_ovf_s;
  logic [XLEN-1:0] a_abs_s;
  logic [XLEN-1:0] b_abs_s;
  logic [XLEN-1:0] quo_fix_s;
  logic [XLEN-1:0] rem_fix_s;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvs_r),
    .rem_next (rem_next_s),
    .quo_next (quo_next_s)
  );

  // Special-case detection on the incoming request, abs values and sign fix-up.
  always_comb begin
    op_signed_s = ~op_r[0];
    req_zero_s  = (divisor_i == {XLEN{1'b0}});
    req_ovf_s   = ~div_op_i[0] && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                  && (divisor_i == {XLEN{1'b1}});
    if (op_signed_s && quo_r[XLEN-1]) begin
      a_abs_s = ~quo_r + ONE_C;
    end else begin
      a_abs_s = quo_r;
    end
    if (op_signed_s && dvs_r[XLEN-1]) begin
      b_abs_s = ~dvs_r + ONE_C;
    end else begin
      b_abs_s = dvs_r;
    end
    if (quo_neg_r) begin
      quo_fix_s = ~quo_r + ONE_C;
    end else begin
      quo_fix_s = quo_r;
    end
    if (rem_neg_r) begin
      rem_fix_s = ~rem_r[XLEN-1:0] + ONE_C;
    end else begin
      rem_fix_s = rem_r[XLEN-1:0];
    end
  end

  // Sequencing FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_DIV;
      rem_r     <= {(XLEN+1){1'b0}};
      quo_r     <= {XLEN{1'b0}};
      dvs_r     <= {XLEN{1'b0}};
      result_r  <= {XLEN{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      quo_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      ack_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else if (flush_i) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= 1'b0;
          if (div_req_i) begin
            op_r      <= type_div_op_e'(div_op_i);
            quo_r     <= dividend_i;
            dvs_r     <= divisor_i;
            rem_r     <= {(XLEN+1){1'b0}};
            quo_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            busy_r    <= 1'b1;
            if (req_zero_s) begin
              result_r <= div_op_i[1] ? dividend_i : {XLEN{1'b1}};
              ack_r    <= 1'b1;
              state_r  <= ST_DONE;
            end else if (req_ovf_s) begin
              result_r <= div_op_i[1] ? {XLEN{1'b0}} : dividend_i;
              ack_r    <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              state_r <= ST_PREP;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_PREP: begin
          quo_r     <= a_abs_s;
          dvs_r     <= b_abs_s;
          quo_neg_r <= op_signed_s & (quo_r[XLEN-1] ^ dvs_r[XLEN-1]);
          rem_neg_r <= op_signed_s & quo_r[XLEN-1];
          cnt_r     <= CNT_W'(XLEN - 1);
          state_r   <= ST_CALC;
        end
        ST_CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= ST_FIX;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FIX: begin
          result_r <= op_r[1] ? rem_fix_s : quo_fix_s;
          ack_r    <= 1'b1;
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // A flush in the DONE cycle must kill the ack in that same cycle.
  assign div_ack_o    = ack_r & ~flush_i;
  assign div_result_o = result_r;
  assign div_busy_o   = busy_r;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed RISC-V corner cases plus random
// operations against an arithmetic reference model.
module tb_div_seq;

  logic        clk;
  logic        rst_n;
  logic        div_req;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        div_ack;
  logic [31:0] div_result;
  logic        div_busy;

  int n_vec = 0;
  int n_err = 0;

  div_seq #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_req_i    (div_req),
    .div_op_i     (div_op),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .flush_i      (flush),
    .div_ack_o    (div_ack),
    .div_result_o (div_result),
    .div_busy_o   (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference: RISC-V M-extension semantics using native integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'b01:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one op from IDLE (mid-cycle = cycle 0) and check latency, result, busy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    logic [31:0] res;
    logic        busy_ok;
    exp_res  = model(op, a, b);
    exp_lat  = is_special(op, a, b) ? 1 : 35;
    lat      = 0;
    res      = 32'd0;
    busy_ok  = 1'b1;
    div_req  = 1'b1;
    div_op   = op;
    dividend = a;
    divisor  = b;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      tick();
      if (!div_busy) busy_ok = 1'b0;
      if (div_ack) begin
        lat     = c;
        res     = div_result;
        div_req = 1'b0;
      end
    end
    div_req = 1'b0;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, res, exp_res);
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    tick();
    chk({tag, " single ack"}, {31'd0, div_ack}, 32'd0);
    chk({tag, " idle"}, {31'd0, div_busy}, 32'd0);
  endtask

  initial begin
    logic        early;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n    = 1'b0;
    div_req  = 1'b0;
    div_op   = 2'b00;
    dividend = 32'd0;
    divisor  = 32'd0;
    flush    = 1'b0;
    tick();
    tick();
    chk("reset ack", {31'd0, div_ack}, 32'd0);
    chk("reset busy", {31'd0, div_busy}, 32'd0);
    chk("reset result", div_result, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(2'b01, 32'd100, 32'd7, "divu 100/7");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem -7/2");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    run_op(2'b01, 32'hDEAD_BEEF, 32'd0, "divu by 0");
    run_op(2'b11, 32'h0000_1234, 32'd0, "remu by 0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu ovf");
    run_op(2'b00, 32'h8000_0000, 32'd3, "div min/3");

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb, "random");
    end

    // Flush a DIV in cycle 10, then restart with DIVU 9/3 in cycle 11.
    early    = 1'b0;
    div_req  = 1'b1;
    div_op   = 2'b00;
    dividend = 32'd1000;
    divisor  = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (div_ack) early = 1'b1;
    end
    flush   = 1'b1;
    div_req = 1'b0;
    #1;
    chk("flush ack suppressed", {31'd0, div_ack}, 32'd0);
    chk("flush no ack before", {31'd0, early}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush busy low", {31'd0, div_busy}, 32'd0);
    run_op(2'b01, 32'd9, 32'd3, "post flush");

    // Flush coincident with a request in IDLE blocks the accept.
    div_req = 1'b1;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    div_req = 1'b0;
    chk("flush blocks accept", {31'd0, div_busy}, 32'd0);
    tick();
    chk("flush blocks accept 2", {31'd0, div_busy}, 32'd0);

    // Async reset mid-operation, then a held request after release.
    div_req  = 1'b1;
    div_op   = 2'b01;
    dividend = 32'd50;
    divisor  = 32'd5;
    for (int c = 1; c <= 20; c++) tick();
    rst_n = 1'b0;
    #1;
    chk("async rst ack", {31'd0, div_ack}, 32'd0);
    chk("async rst busy", {31'd0, div_busy}, 32'd0);
    chk("async rst result", div_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, "held req");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
